// File: rtl/usb_pkg.sv
// Shared USB definitions: CRC16 constants and the receive assembler state type.
// Imported by the CRC helper and the packet assembler.
package usb_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } asm_state_e;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational USB CRC16 step over one byte, reflected, LSB first.
// Ports: crc_i current CRC, data_i byte, crc_o CRC after the byte.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data_i[i]) ? CRC16_POLY_REFL : 16'h0000);
        end
        crc_o = c;
    end

endmodule

// File: rtl/usb_rx_packet_assembler.sv
// Collects received bytes into one fixed-length packet with CRC16 check and
// presents it with valid/ready. Ports: clk, n_rst, rx_byte/new_byte in,
// rx_abort flush, pkt_ready in; pkt_data, pkt_valid, crc_ok, busy, overflow out.
module usb_rx_packet_assembler
    import usb_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 64
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [7:0]                     rx_byte,
    input  logic                           new_byte,
    input  logic                           rx_abort,
    input  logic                           pkt_ready,
    output logic [(PAYLOAD_BYTES+2)*8-1:0] pkt_data,
    output logic                           pkt_valid,
    output logic                           crc_ok,
    output logic                           busy,
    output logic                           overflow
);

    localparam int NBYTES = PAYLOAD_BYTES + 2;
    localparam int CW     = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    asm_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [15:0]         crc_q;
    logic [15:0]         crc_d;
    logic [NBYTES*8-1:0] data_q;
    logic                valid_q;
    logic                ok_q;
    logic                busy_q;
    logic                ovf_q;

    // crc_q sits at CRC16_INIT while holding, so crc_d also serves as
    // the CRC of byte 0 when it arrives together with the handshake.
    usb_crc16_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_byte),
        .crc_o  (crc_d)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            crc_q   <= CRC16_INIT;
            data_q  <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (rx_abort) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            crc_q   <= CRC16_INIT;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unique case (state_q)
                COLLECT: begin
                    if (new_byte) begin
                        data_q[{cnt_q, 3'b000} +: 8] <= rx_byte;
                        if (cnt_q == LAST) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            ok_q    <= (crc_d == CRC16_RESIDUAL);
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            crc_q   <= CRC16_INIT;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            crc_q  <= crc_d;
                            busy_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        state_q <= COLLECT;
                        valid_q <= 1'b0;
                        if (new_byte) begin
                            data_q[7:0] <= rx_byte;
                            cnt_q       <= CW'(1);
                            crc_q       <= crc_d;
                            busy_q      <= 1'b1;
                        end
                    end else begin
                        ovf_q <= new_byte;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign pkt_data  = data_q;
    assign pkt_valid = valid_q;
    assign crc_ok    = ok_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_usb_rx_packet_assembler.sv
// Randomized and directed bench for usb_rx_packet_assembler against a
// queue-based packet model.
module tb_usb_rx_packet_assembler;

    localparam int PB = 64;
    localparam int NB = PB + 2;
    localparam int W  = NB * 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [7:0]   rx_byte;
    logic         new_byte;
    logic         rx_abort;
    logic         pkt_ready;
    logic [W-1:0] pkt_data;
    logic         pkt_valid;
    logic         crc_ok;
    logic         busy;
    logic         overflow;

    always #5 clk = ~clk;

    usb_rx_packet_assembler #(.PAYLOAD_BYTES(PB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_byte   (rx_byte),
        .new_byte  (new_byte),
        .rx_abort  (rx_abort),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .crc_ok    (crc_ok),
        .busy      (busy),
        .overflow  (overflow)
    );

    logic [7:0]   cur[$];
    logic [7:0]   pk[$];
    bit           m_hold;
    logic [W-1:0] m_data;
    bit           m_ok;
    bit           m_ok_def;
    bit           m_ovf;
    int           n_chk = 0;
    int           n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] q[$], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ q[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic model_reset();
        cur.delete();
        m_hold   = 0;
        m_data   = '0;
        m_ok     = 0;
        m_ok_def = 1;
        m_ovf    = 0;
    endtask

    task automatic model_update(input bit nb, input logic [7:0] b,
                                input bit ab, input bit rdy);
        m_ovf = 0;
        if (ab) begin
            cur.delete();
            m_hold   = 0;
            m_ok     = 0;
            m_ok_def = 1;
        end else if (m_hold) begin
            if (rdy) begin
                m_hold   = 0;
                m_ok_def = 0;
                if (nb) begin
                    m_data[7:0] = b;
                    cur.push_back(b);
                end
            end else if (nb) begin
                m_ovf = 1;
            end
        end else if (nb) begin
            m_data[cur.size()*8 +: 8] = b;
            cur.push_back(b);
            if (cur.size() == NB) begin
                m_hold   = 1;
                m_ok     = (crc16(cur, NB) == 16'hB001);
                m_ok_def = 1;
                cur.delete();
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".valid"}, pkt_valid, m_hold);
        chk({ph, ".busy"}, busy, cur.size() > 0);
        chk({ph, ".ovf"}, overflow, m_ovf);
        chk({ph, ".data"}, pkt_data, m_data);
        if (m_ok_def) chk({ph, ".crc_ok"}, crc_ok, m_ok);
    endtask

    task automatic step(input bit nb, input logic [7:0] b, input bit ab,
                        input bit rdy, input string ph);
        new_byte  = nb;
        rx_byte   = b;
        rx_abort  = ab;
        pkt_ready = rdy;
        @(posedge clk);
        model_update(nb, b, ab, rdy);
        #1;
        check_all(ph);
        new_byte  = 0;
        rx_abort  = 0;
        pkt_ready = 0;
    endtask

    task automatic do_reset(input string ph);
        @(negedge clk);
        n_rst = 0;
        #1;
        model_reset();
        check_all(ph);
        @(negedge clk);
        n_rst = 1;
    endtask

    task automatic build(input bit good, input bit digits);
        logic [15:0] c;
        pk.delete();
        for (int i = 0; i < PB; i++) begin
            if (digits && i < 9) pk.push_back(8'h31 + 8'(i));
            else pk.push_back(8'($urandom));
        end
        c = ~crc16(pk, PB);
        pk.push_back(c[7:0]);
        pk.push_back(c[15:8]);
        if (!good) pk[NB-1] = pk[NB-1] ^ 8'h01;
    endtask

    task automatic send(input int from, input int to, input string ph);
        for (int i = from; i < to; i++) step(1, pk[i], 0, 0, ph);
    endtask

    initial begin
        logic [7:0] b;
        bit         nb, ab, rdy, gm;
        logic [15:0] c;
        n_rst = 0; rx_byte = 0; new_byte = 0; rx_abort = 0; pkt_ready = 0;
        gm = 0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        n_rst = 1;

        build(1, 1);
        send(0, NB, "good");
        chk("good.ok", crc_ok, 1'b1);
        chk("good.b0", pkt_data[7:0], 8'h31);
        chk("good.last", pkt_data[W-1 -: 8], pk[NB-1]);
        step(0, 0, 0, 1, "good.hs");

        build(0, 1);
        send(0, NB, "bad");
        chk("bad.ok", crc_ok, 1'b0);
        step(0, 0, 0, 0, "bad.idle");
        step(0, 0, 0, 1, "bad.hs");

        build(1, 0);
        send(0, NB, "ovf.pkt");
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0, "ovf.drop");
        step(0, 0, 0, 0, "ovf.idle");
        step(0, 0, 0, 1, "ovf.rel");
        build(1, 0);
        send(0, NB, "ovf.next");
        chk("ovf.next.ok", crc_ok, 1'b1);

        step(1, 8'hAA, 0, 1, "sim");
        chk("sim.b0", pkt_data[7:0], 8'hAA);
        chk("sim.busy", busy, 1'b1);
        chk("sim.ovf", overflow, 1'b0);
        for (int i = 1; i < 20; i++) step(1, 8'($urandom), 0, 0, "ab.fill");
        step(1, 8'h55, 1, 1, "abort");
        chk("abort.busy", busy, 1'b0);
        build(1, 0);
        send(0, NB, "ab.clean");
        chk("ab.clean.ok", crc_ok, 1'b1);
        chk("ab.clean.b0", pkt_data[7:0], pk[0]);

        do_reset("rst.hold");
        build(1, 0);
        send(0, 10, "rst.part");
        do_reset("rst.mid");
        build(1, 0);
        send(0, NB, "rst.after");
        chk("rst.after.ok", crc_ok, 1'b1);
        step(0, 0, 0, 1, "rst.hs");

        for (int k = 0; k < 3000; k++) begin
            nb  = $urandom_range(0, 9) < 7;
            ab  = $urandom_range(0, 299) == 0;
            rdy = $urandom_range(0, 3) == 0;
            b   = 8'($urandom);
            if (!m_hold && cur.size() == PB) begin
                gm = $urandom_range(0, 1) == 1;
                c  = ~crc16(cur, PB);
                if (gm) b = c[7:0];
            end else if (!m_hold && cur.size() == PB + 1 && gm) begin
                c = ~crc16(cur, PB);
                b = c[15:8];
            end
            step(nb, b, ab, rdy, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
